// File: rtl/rect_raster_if.sv
// Handshake bundle between a rectangle requester and rect_raster.
//   master: drives start/geometry/colour/mode and the framebuffer ready.
//   slave : the rasteriser; presents pixels (x_out/y_out/c_out/plot) and status.
interface rect_raster_if #(
  parameter int unsigned XW = 8,
  parameter int unsigned YW = 7,
  parameter int unsigned SW = 5,
  parameter int unsigned CW = 3
);
  logic          start;
  logic [XW-1:0] x_in;
  logic [YW-1:0] y_in;
  logic [SW-1:0] width;
  logic [SW-1:0] height;
  logic [CW-1:0] c_in;
  logic [1:0]    mode;
  logic          ready;
  logic [XW-1:0] x_out;
  logic [YW-1:0] y_out;
  logic [CW-1:0] c_out;
  logic          plot;
  logic          busy;
  logic          done;

  modport master (
    output start, x_in, y_in, width, height, c_in, mode, ready,
    input  x_out, y_out, c_out, plot, busy, done
  );

  modport slave (
    input  start, x_in, y_in, width, height, c_in, mode, ready,
    output x_out, y_out, c_out, plot, busy, done
  );
endinterface

// File: rtl/rect_raster.sv
// Rectangle rasteriser. Walks a WxH rectangle in row-major order and presents one
// pixel per scan position; fill, outline and clear modes; off-screen pixels are
// clipped (they still take one cycle but never plot).
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - rect_raster_if.slave: start/x_in/y_in/width/height/c_in/mode/ready in,
//           x_out/y_out/c_out/plot/busy/done out
module rect_raster #(
  parameter int unsigned XW       = 8,
  parameter int unsigned YW       = 7,
  parameter int unsigned SW       = 5,
  parameter int unsigned CW       = 3,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input logic          clk,
  input logic          reset,
  rect_raster_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StScan = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [1:0] ModeOutline = 2'b01;
  localparam logic [1:0] ModeClear   = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] cx_q, cx_d;
  logic [SW-1:0] cy_q, cy_d;
  logic [SW-1:0] w_q, h_q;
  logic [XW-1:0] x_base_q;
  logic [YW-1:0] y_base_q;
  logic [CW-1:0] c_q;
  logic [1:0]    mode_q;
  logic          latch;

  // One extra bit so a rectangle running past the coordinate range is clipped
  // rather than wrapping back onto the left/top of the screen.
  logic [XW:0] x_sum;
  logic [YW:0] y_sum;
  logic        last_col, last_row;
  logic        candidate, in_bounds, plot_int, advance;

  assign x_sum = (XW+1)'(x_base_q) + (XW+1)'(cx_q);
  assign y_sum = (YW+1)'(y_base_q) + (YW+1)'(cy_q);

  assign last_col  = (cx_q == w_q - SW'(1));
  assign last_row  = (cy_q == h_q - SW'(1));
  assign candidate = (mode_q != ModeOutline) ||
                     (cx_q == '0) || last_col || (cy_q == '0) || last_row;
  assign in_bounds = (x_sum < (XW+1)'(SCREEN_W)) && (y_sum < (YW+1)'(SCREEN_H));
  assign plot_int  = (state_q == StScan) && candidate && in_bounds;
  // A presented pixel stalls until the framebuffer takes it.
  assign advance   = !plot_int || bus.ready;

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    latch   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          latch   = 1'b1;
          cx_d    = '0;
          cy_d    = '0;
          state_d = (bus.width != '0 && bus.height != '0) ? StScan : StDone;
        end
      end
      StScan: begin
        if (advance) begin
          if (last_col) begin
            cx_d = '0;
            if (last_row) begin
              cy_d    = '0;
              state_d = StDone;
            end else begin
              cy_d = cy_q + SW'(1);
            end
          end else begin
            cx_d = cx_q + SW'(1);
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cx_q     <= '0;
      cy_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      x_base_q <= '0;
      y_base_q <= '0;
      c_q      <= '0;
      mode_q   <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      if (latch) begin
        x_base_q <= bus.x_in;
        y_base_q <= bus.y_in;
        w_q      <= bus.width;
        h_q      <= bus.height;
        c_q      <= bus.c_in;
        mode_q   <= bus.mode;
      end
    end
  end

  assign bus.x_out = x_sum[XW-1:0];
  assign bus.y_out = y_sum[YW-1:0];
  assign bus.c_out = (state_q == StScan && mode_q != ModeClear) ? c_q : '0;
  assign bus.plot  = plot_int;
  assign bus.busy  = (state_q == StScan) || (state_q == StDone);
  assign bus.done  = (state_q == StDone);

endmodule
